osd_rom_arbiter: RTL
====================

OSD_ROM_ARBITER -- requirements
Module: osd_rom_arbiter

Interface
REQ-001 SHALL have parameter PORT_NUM, default 5: number of client ports, legal range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 13: ROM address width.
REQ-003 SHALL have parameter DATA_W, default 16: ROM data width.
REQ-004 SHALL have parameter RD_LAT, default 1: ROM read latency in cycles from o_rom_addr to i_rom_data, legal range 1..4.
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 selects round-robin, 1 selects fixed priority with the highest index winning.
REQ-006 SHALL have ports:
- i_clk      in   1                 the only clock; all logic on its rising edge.
- i_rst      in   1                 synchronous, active-high reset.
- i_req      in   PORT_NUM          per-port read request; held high with a stable address until acked.
- i_rd_addr  in   PORT_NUM*ADDR_W   per-port address; port k uses bits [k*ADDR_W +: ADDR_W].
- o_ack      out  PORT_NUM          one-hot, combinational; the request is accepted this cycle.
- o_rvalid   out  PORT_NUM          one-hot, registered; one-cycle read-data-valid pulse.
- o_rd_data  out  PORT_NUM*DATA_W   per-port data; port k uses bits [k*DATA_W +: DATA_W].
- o_rom_en   out  1                 registered ROM read enable.
- o_rom_addr out  ADDR_W            registered ROM address.
- i_rom_data in   DATA_W            ROM read data, valid RD_LAT cycles after o_rom_en/o_rom_addr.

Function
REQ-007 SHALL accept at most one request per cycle; o_ack SHALL be zero or one-hot and SHALL have o_ack[k]=1 only when i_req[k]=1.
REQ-008 SHALL, when any i_req bit is high and i_rst=0, assert exactly one o_ack bit in the same cycle, so there are no idle cycles while requests are pending.
REQ-009 SHALL, in round-robin mode, search the ports starting at rr_ptr and wrapping modulo PORT_NUM, grant the first requester k, and then update rr_ptr to (k+1) mod PORT_NUM at the clock edge. rr_ptr SHALL be unchanged when nothing is granted.
REQ-010 SHALL, in fixed-priority mode, grant the highest-index requesting port; rr_ptr is unused.
REQ-011 SHALL, on the edge ending ack cycle T, register o_rom_addr = i_rd_addr of the granted port and o_rom_en = 1. With no grant, o_rom_en = 0 and o_rom_addr holds its previous value.
REQ-012 SHALL carry a tag (valid bit plus granted port index) through a shift pipeline aligned to RD_LAT, so the tag arrives with i_rom_data at cycle T+1+RD_LAT.
REQ-013 SHALL, on the edge ending cycle T+1+RD_LAT, register i_rom_data into the tagged port's o_rd_data slice and pulse that port's o_rvalid. The pulse is visible in cycle T+2+RD_LAT, so total latency from ack to rvalid is RD_LAT+2.
REQ-014 SHALL drive o_rd_data slices of non-valid ports to zero; the valid port's slice SHALL be zero whenever its o_rvalid=0.
REQ-015 SHALL sustain one read per cycle back-to-back, with responses returned in grant order and no loss or duplication.
REQ-016 SHALL ignore i_rd_addr of ports not granted in the cycle and SHALL ignore i_rom_data in cycles with no tag.
REQ-017 SHALL let a port deasserting i_req before its ack withdraw the request without error; no ack and no rvalid result for that port.

Reset
REQ-018 SHALL, while i_rst=1, force o_ack=0 combinationally and accept no request.
REQ-019 SHALL, on a clock edge with i_rst=1, clear rr_ptr=0, all pipeline tags, o_rvalid=0, o_rd_data=0, o_rom_en=0 and o_rom_addr=0.
REQ-020 SHALL drop reads in flight when reset is applied mid-operation, so no o_rvalid is produced for them after reset is released.
REQ-021 SHALL be able to grant in the first cycle after i_rst falls.

Verification
REQ-022 Single read, default parameters, i_req=5'b00100 with port-2 address 13'h0123 and the ROM model returning 16'hBEEF: o_ack=5'b00100 in cycle T, o_rom_addr=13'h0123 in T+1, o_rvalid=5'b00100 and o_rd_data[47:32]=16'hBEEF in T+3, all other slices 0.
REQ-023 Round-robin with all five i_req held high continuously: acks rotate ports 0,1,2,3,4,0 on consecutive cycles and rvalid pulses follow the same order at 3-cycle lag.
REQ-024 ARB_MODE=1, i_req=5'b10011 held: port 4 is acked; after it drops, port 1, then port 0.
REQ-025 RD_LAT=3, back-to-back grants to ports 0 then 3 with the ROM returning address+1: rvalids at T+5 and T+6 carrying the correct data per port.
REQ-026 Reset asserted one cycle after a grant, held 2 cycles: no o_rvalid is ever produced for that grant; after release, i_req=5'b00001 is acked in the first cycle.

Source files
------------

// File: rtl/osd_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : osd_rom_arbiter
// Function : Shares one pipelined ROM between PORT_NUM read clients and routes
//            each read response back to its requester via a latency-matched tag.
// Revision : 1.0
// ============================================================================
module osd_rom_arbiter #(
    parameter int PORT_NUM = 5,
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [PORT_NUM-1:0]        i_req,
    input  logic [PORT_NUM*ADDR_W-1:0] i_rd_addr,
    output logic [PORT_NUM-1:0]        o_ack,
    output logic [PORT_NUM-1:0]        o_rvalid,
    output logic [PORT_NUM*DATA_W-1:0] o_rd_data,
    output logic                       o_rom_en,
    output logic [ADDR_W-1:0]          o_rom_addr,
    input  logic [DATA_W-1:0]          i_rom_data
);

    localparam int                 c_idx_w    = $clog2(PORT_NUM);
    localparam int                 c_cnt_w    = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_port_num = c_cnt_w'(PORT_NUM);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PORT_NUM - 1);

    logic [c_idx_w-1:0]          r_rr_ptr;
    logic                        r_rom_en;
    logic [ADDR_W-1:0]           r_rom_addr;
    logic                        r_tag_vld [RD_LAT+1];
    logic [c_idx_w-1:0]          r_tag_idx [RD_LAT+1];
    logic [PORT_NUM-1:0]         r_rvalid;
    logic [PORT_NUM*DATA_W-1:0]  r_rd_data;

    logic [c_idx_w-1:0]          w_grant_idx;
    logic [c_cnt_w-1:0]          w_rot;
    logic                        w_grant_vld;
    logic [ADDR_W-1:0]           w_grant_addr;
    logic [c_idx_w-1:0]          w_next_ptr;

    always_comb begin
        w_grant_idx = '0;
        w_rot       = '0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (i_req[i]) w_grant_idx = c_idx_w'(i);
            end
        end else begin
            // Scan backwards so the surviving hit is the nearest requester at or after r_rr_ptr.
            for (int i = PORT_NUM - 1; i >= 0; i--) begin
                w_rot = {1'b0, r_rr_ptr} + c_cnt_w'(i);
                if (w_rot >= c_port_num) w_rot = w_rot - c_port_num;
                if (i_req[w_rot[c_idx_w-1:0]]) w_grant_idx = w_rot[c_idx_w-1:0];
            end
        end
    end

    assign w_grant_vld = (|i_req) && !i_rst;
    assign w_next_ptr  = (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + c_idx_w'(1);
    assign o_ack       = w_grant_vld ? ({{(PORT_NUM-1){1'b0}}, 1'b1} << w_grant_idx) : '0;

    always_comb begin
        w_grant_addr = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (w_grant_idx == c_idx_w'(k)) w_grant_addr = i_rd_addr[k*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr   <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_rom_en <= w_grant_vld;
            if (w_grant_vld) begin
                r_rom_addr <= w_grant_addr;
                if (ARB_MODE == 0) r_rr_ptr <= w_next_ptr;
            end
        end
    end

    // Stage 0 lines up with o_rom_addr; stage RD_LAT lines up with i_rom_data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s <= RD_LAT; s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_idx[s] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_grant_vld;
            r_tag_idx[0] <= w_grant_idx;
            for (int s = 1; s <= RD_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid  <= '0;
            r_rd_data <= '0;
        end else begin
            for (int k = 0; k < PORT_NUM; k++) begin
                if (r_tag_vld[RD_LAT] && (r_tag_idx[RD_LAT] == c_idx_w'(k))) begin
                    r_rvalid[k]                    <= 1'b1;
                    r_rd_data[k*DATA_W +: DATA_W]  <= i_rom_data;
                end else begin
                    r_rvalid[k]                    <= 1'b0;
                    r_rd_data[k*DATA_W +: DATA_W]  <= '0;
                end
            end
        end
    end

    assign o_rom_en   = r_rom_en;
    assign o_rom_addr = r_rom_addr;
    assign o_rvalid   = r_rvalid;
    assign o_rd_data  = r_rd_data;

endmodule
`default_nettype wire
